pe_grid_multicast_feeder: RTL and testbench
===========================================

Name: pe_grid_multicast_feeder

Overview:
- Transmit side of the PE grid's tagged multicast buses.
- Reads weights and image values from a 1-cycle-latency buffer port and issues them to the grid:
  - weights as weight_val_in/tag_row/valid_y;
  - image values as image_val_in/tag_col/valid_x.
- After issuing, waits a fixed drain interval, then captures all column psum outputs and reports done.
- Sits between the global buffer / top-level controller and the 12x14 PE grid.

Parameters:
- ROWS, 12, PE grid rows; tag_row range 0..ROWS-1.
- COLS, 14, PE grid columns; tag_col range 0..COLS-1.
- DATA_W, 16, weight/image value width.
- PSUM_W, 32, psum width per column.
- ADDR_W, 10, buffer address width.
- DRAIN_CYCLES, 12, cycles waited after the last bus beat before psum capture.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle request; accepted only in IDLE.
- w_base  in  ADDR_W  buffer address of weight 0; sampled at start.
- i_base  in  ADDR_W  buffer address of image value 0; sampled at start.
- num_rows  in  4  weights to issue; sampled at start.
- num_cols  in  4  image values to issue; sampled at start.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when results are captured.
- mem_rd_en  out  1  buffer read strobe.
- mem_rd_addr  out  ADDR_W  buffer read address.
- mem_rd_data  in  DATA_W  read data, valid exactly 1 cycle after mem_rd_en.
- weight_val_in  out  DATA_W  weight multicast value.
- tag_row  out  4  destination row tag.
- valid_y  out  1  weight bus valid.
- image_val_in  out  DATA_W  image multicast value.
- tag_col  out  4  destination column tag.
- valid_x  out  1  image bus valid.
- psum_outs_in  in  COLS*PSUM_W  grid column outputs; column c at bits [c*PSUM_W +: PSUM_W].
- result_out  out  COLS*PSUM_W  captured psums, held until next capture or reset.

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE.
  - All outputs are 0, including result_out; internal counters and the read pipeline are cleared.
  - A reset mid-operation abandons the run with no done pulse.
- start:
  - In IDLE, start=1 latches w_base, i_base, num_rows and num_cols, then enters W_ISSUE.
  - start in any other state is ignored.
  - num_rows > ROWS is clamped to ROWS; num_cols > COLS is clamped to COLS.
- States: IDLE, W_ISSUE, I_ISSUE, FLUSH, DRAIN, CAPTURE.
- W_ISSUE:
  - Read k (k = 0..num_rows-1) has mem_rd_en=1 and mem_rd_addr = w_base+k, one read per cycle, back-to-back.
  - Address arithmetic wraps modulo 2^ADDR_W.
  - After the last read, go to I_ISSUE.
  - If num_rows=0, W_ISSUE is skipped.
- I_ISSUE: same as W_ISSUE, using i_base+k for k = 0..num_cols-1. If num_cols=0, it is skipped.
- Read pipeline:
  - A read issued in cycle t returns mem_rd_data in t+1.
  - That data is registered onto the bus; the bus beat (valid=1, value, tag=k) is visible in cycle t+2 for exactly one cycle.
- Bus rules:
  - Weight beats drive only the weight bus; image beats drive only the image bus.
  - Between beats, valid=0, value=0, tag=0.
  - valid_x and valid_y are never high in the same cycle: the first image beat follows the last weight beat by exactly one cycle.
- FLUSH: lasts 2 cycles after the last read, until the final beat has been driven. If both counts are 0, FLUSH is entered directly.
- DRAIN:
  - Counts DRAIN_CYCLES cycles, starting the cycle after the final beat.
  - Then CAPTURE: result_out <= psum_outs_in, done=1 for one cycle, busy=0 in that same cycle, return to IDLE.
- Latency: start accepted in cycle s gives done in cycle s + 1 + (num_rows + num_cols) + 2 + DRAIN_CYCLES when counts are nonzero.
- start asserted in the done cycle is ignored; it is accepted in the next IDLE cycle.
- The feeder applies no backpressure and has no stall input. The buffer must meet the fixed 1-cycle latency.

Test Plan:
- Reset mid-W_ISSUE:
  - Stimulus: start, num_rows=12, num_cols=14; assert rst after 5 cycles.
  - Required: all outputs 0 immediately (asynchronous); no done; a fresh start afterwards runs normally.
- Single-PE run:
  - Stimulus: buffer[0]=3, buffer[100]=30; w_base=0, i_base=100, num_rows=1, num_cols=1; behavioural grid model.
  - Required: one beat valid_y with tag_row=0 and value 3, then next cycle valid_x with tag_col=0 and value 30; done at s+17; result_out column 0 = 90.
- Full sweep:
  - Stimulus: num_rows=12, num_cols=14, buffer[w_base+k]=k+1, buffer[i_base+k]=10*k.
  - Required: 26 consecutive beats with tags 0..11 then 0..13, values match buffer; valid_x & valid_y never both 1; done at s+41.
- Clamping and zero counts:
  - Stimulus: num_rows=15, num_cols=0.
  - Required: exactly 12 weight beats and no image beats.
  - Stimulus: num_rows=0, num_cols=0.
  - Required: no mem_rd_en; done at s+15.
- Address wrap:
  - Stimulus: w_base=1022, num_rows=4.
  - Required: mem_rd_addr sequence 1022, 1023, 0, 1.
- start while busy:
  - Stimulus: pulse start again mid-run and in the done cycle.
  - Required: both ignored; bases/counts unchanged; exactly one done.

Source files
------------

// File: rtl/pe_grid_multicast_feeder.sv
// Transmit side of the PE grid multicast buses: reads weights then image values from a
// 1-cycle-latency buffer, drives them as tagged beats, drains, then captures column psums.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | waiting for start; bases and counts latched on accept
// S_W_ISSUE | one weight read per cycle, k = 0..num_rows-1
// S_I_ISSUE | one image read per cycle, k = 0..num_cols-1
// S_FLUSH   | 2 cycles for the last read to reach the bus
// S_DRAIN   | DRAIN_CYCLES cycles for the grid to settle
// S_CAPTURE | done pulse; result_out already holds the captured psums
module pe_grid_multicast_feeder #(
   parameter int ROWS         = 12,
   parameter int COLS         = 14,
   parameter int DATA_W       = 16,
   parameter int PSUM_W       = 32,
   parameter int ADDR_W       = 10,
   parameter int DRAIN_CYCLES = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [ADDR_W-1:0]      w_base,
   input  logic [ADDR_W-1:0]      i_base,
   input  logic [3:0]             num_rows,
   input  logic [3:0]             num_cols,
   output logic                   busy,
   output logic                   done,
   output logic                   mem_rd_en,
   output logic [ADDR_W-1:0]      mem_rd_addr,
   input  logic [DATA_W-1:0]      mem_rd_data,
   output logic [DATA_W-1:0]      weight_val_in,
   output logic [3:0]             tag_row,
   output logic                   valid_y,
   output logic [DATA_W-1:0]      image_val_in,
   output logic [3:0]             tag_col,
   output logic                   valid_x,
   input  logic [COLS*PSUM_W-1:0] psum_outs_in,
   output logic [COLS*PSUM_W-1:0] result_out
);
   localparam int TMR_W = $clog2(DRAIN_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_W_ISSUE, S_I_ISSUE, S_FLUSH, S_DRAIN, S_CAPTURE
   } state_t;

   state_t                   r_state, w_nxt;
   logic [ADDR_W-1:0]        r_w_base, r_i_base;
   logic [3:0]               r_num_rows, r_num_cols;
   logic [3:0]               r_cnt;
   logic [TMR_W-1:0]         r_tmr;
   logic                     r_rd_vld, r_rd_img;
   logic [3:0]               r_rd_tag;
   logic [DATA_W-1:0]        r_w_val, r_i_val;
   logic [3:0]               r_w_tag, r_i_tag;
   logic                     r_w_vld, r_i_vld;
   logic [COLS*PSUM_W-1:0]   r_result;
   logic [3:0]               w_nr_clamp, w_nc_clamp;
   logic                     w_rd_w, w_rd_i;

   assign w_nr_clamp = (num_rows > 4'(ROWS)) ? 4'(ROWS) : num_rows;
   assign w_nc_clamp = (num_cols > 4'(COLS)) ? 4'(COLS) : num_cols;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               if (w_nr_clamp != 4'd0)      w_nxt = S_W_ISSUE;
               else if (w_nc_clamp != 4'd0) w_nxt = S_I_ISSUE;
               else                         w_nxt = S_FLUSH;
            end
         end
         S_W_ISSUE: begin
            if (r_cnt == r_num_rows - 4'd1)
               w_nxt = (r_num_cols != 4'd0) ? S_I_ISSUE : S_FLUSH;
         end
         S_I_ISSUE: if (r_cnt == r_num_cols - 4'd1) w_nxt = S_FLUSH;
         S_FLUSH:   if (r_tmr == '0) w_nxt = S_DRAIN;
         S_DRAIN:   if (r_tmr == '0) w_nxt = S_CAPTURE;
         S_CAPTURE: w_nxt = S_IDLE;
         default:   w_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_rd_w      = (r_state == S_W_ISSUE);
      w_rd_i      = (r_state == S_I_ISSUE);
      mem_rd_en   = w_rd_w | w_rd_i;
      mem_rd_addr = '0;
      if (w_rd_w)      mem_rd_addr = r_w_base + ADDR_W'(r_cnt);
      else if (w_rd_i) mem_rd_addr = r_i_base + ADDR_W'(r_cnt);
      busy = (r_state != S_IDLE) && (r_state != S_CAPTURE);
      done = (r_state == S_CAPTURE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_w_base   <= '0;
         r_i_base   <= '0;
         r_num_rows <= '0;
         r_num_cols <= '0;
         r_cnt      <= '0;
         r_tmr      <= '0;
      end else begin
         if (r_state == S_IDLE && start) begin
            r_w_base   <= w_base;
            r_i_base   <= i_base;
            r_num_rows <= w_nr_clamp;
            r_num_cols <= w_nc_clamp;
         end
         if (r_state != w_nxt)  r_cnt <= '0;
         else if (mem_rd_en)    r_cnt <= r_cnt + 4'd1;
         // FLUSH holds 2 cycles (1 -> 0); DRAIN holds DRAIN_CYCLES cycles
         if (w_nxt == S_FLUSH && r_state != S_FLUSH)      r_tmr <= TMR_W'(1);
         else if (w_nxt == S_DRAIN && r_state != S_DRAIN) r_tmr <= TMR_W'(DRAIN_CYCLES - 1);
         else if (r_tmr != '0)                            r_tmr <= r_tmr - TMR_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_vld <= 1'b0;
         r_rd_img <= 1'b0;
         r_rd_tag <= '0;
         r_w_vld  <= 1'b0;
         r_w_val  <= '0;
         r_w_tag  <= '0;
         r_i_vld  <= 1'b0;
         r_i_val  <= '0;
         r_i_tag  <= '0;
         r_result <= '0;
      end else begin
         r_rd_vld <= mem_rd_en;
         r_rd_img <= w_rd_i;
         r_rd_tag <= mem_rd_en ? r_cnt : 4'd0;
         r_w_vld  <= r_rd_vld & ~r_rd_img;
         r_w_val  <= (r_rd_vld & ~r_rd_img) ? mem_rd_data : '0;
         r_w_tag  <= (r_rd_vld & ~r_rd_img) ? r_rd_tag : 4'd0;
         r_i_vld  <= r_rd_vld & r_rd_img;
         r_i_val  <= (r_rd_vld & r_rd_img) ? mem_rd_data : '0;
         r_i_tag  <= (r_rd_vld & r_rd_img) ? r_rd_tag : 4'd0;
         // sampled on entry to CAPTURE so result_out is valid alongside done
         if (r_state == S_DRAIN && r_tmr == '0) r_result <= psum_outs_in;
      end
   end

   assign weight_val_in = r_w_val;
   assign tag_row       = r_w_tag;
   assign valid_y       = r_w_vld;
   assign image_val_in  = r_i_val;
   assign tag_col       = r_i_tag;
   assign valid_x       = r_i_vld;
   assign result_out    = r_result;

endmodule

// File: tb/tb_pe_grid_multicast_feeder.sv
// Directed bench for pe_grid_multicast_feeder: buffer model, behavioural grid model,
// bus monitor and a table of runs plus reset and start-while-busy sequences.
module tb_pe_grid_multicast_feeder;
   localparam int ROWS = 12, COLS = 14, DATA_W = 16, PSUM_W = 32, ADDR_W = 10, DRAIN = 12;

   logic                   clk = 1'b0;
   logic                   rst, start;
   logic [ADDR_W-1:0]      w_base, i_base, mem_rd_addr;
   logic [3:0]             num_rows, num_cols, tag_row, tag_col;
   logic                   busy, done, mem_rd_en, valid_y, valid_x;
   logic [DATA_W-1:0]      mem_rd_data, weight_val_in, image_val_in;
   logic [COLS*PSUM_W-1:0] psum_outs_in, result_out;

   always #5 clk = ~clk;

   pe_grid_multicast_feeder #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .PSUM_W(PSUM_W),
                              .ADDR_W(ADDR_W), .DRAIN_CYCLES(DRAIN)) dut (
      .clk(clk), .rst(rst), .start(start), .w_base(w_base), .i_base(i_base),
      .num_rows(num_rows), .num_cols(num_cols), .busy(busy), .done(done),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
      .weight_val_in(weight_val_in), .tag_row(tag_row), .valid_y(valid_y),
      .image_val_in(image_val_in), .tag_col(tag_col), .valid_x(valid_x),
      .psum_outs_in(psum_outs_in), .result_out(result_out));

   int checks = 0, failures = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [DATA_W-1:0] mem [1024];
   always @(posedge clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : '0;

   // grid model: each row latches its weight, each column its image value
   logic [DATA_W-1:0] gw [16];
   logic [DATA_W-1:0] gx [16];
   logic g_clr = 1'b1;
   always @(posedge clk) begin
      if (g_clr) begin
         for (int i = 0; i < 16; i++) begin gw[i] <= '0; gx[i] <= '0; end
      end else begin
         if (valid_y) gw[tag_row] <= weight_val_in;
         if (valid_x) gx[tag_col] <= image_val_in;
      end
   end
   always_comb begin
      psum_outs_in = '0;
      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            psum_outs_in[c*PSUM_W +: PSUM_W] = psum_outs_in[c*PSUM_W +: PSUM_W]
                                               + 32'(gw[r]) * 32'(gx[c]);
   end

   // bus monitor
   logic [ADDR_W-1:0] m_wb, m_ib;
   int m_nw, m_ni;
   logic mon_clr = 1'b1;
   int w_seen, i_seen, rd_seen, beats, first_beat, last_beat, done_cnt, done_cyc;
   int w_err, i_err, rd_err, gap_err, idle_err, ovl_err;
   always @(negedge clk) begin : mon
      logic [ADDR_W-1:0] a;
      if (mon_clr) begin
         w_seen = 0; i_seen = 0; rd_seen = 0; beats = 0; first_beat = -1; last_beat = 0;
         done_cnt = 0; done_cyc = 0;
         w_err = 0; i_err = 0; rd_err = 0; gap_err = 0; idle_err = 0; ovl_err = 0;
      end else begin
         if (valid_x && valid_y) ovl_err++;
         if (valid_y) begin
            a = m_wb + ADDR_W'(w_seen);
            if (tag_row != 4'(w_seen) || weight_val_in != mem[a]) w_err++;
            w_seen++;
         end else if (weight_val_in != '0 || tag_row != '0) idle_err++;
         if (valid_x) begin
            a = m_ib + ADDR_W'(i_seen);
            if (tag_col != 4'(i_seen) || image_val_in != mem[a]) i_err++;
            if (w_seen != m_nw) gap_err++;
            i_seen++;
         end else if (image_val_in != '0 || tag_col != '0) idle_err++;
         if (valid_x || valid_y) begin
            if (beats > 0 && cyc != last_beat + 1) gap_err++;
            if (beats == 0) first_beat = cyc;
            last_beat = cyc;
            beats++;
         end
         if (mem_rd_en) begin
            if (rd_seen < m_nw) a = m_wb + ADDR_W'(rd_seen);
            else                a = m_ib + ADDR_W'(rd_seen - m_nw);
            if (mem_rd_addr != a) rd_err++;
            rd_seen++;
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
      end
   end

   task automatic chk(input string nm, input int id, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s[%0d]: got %0d, expected %0d", nm, id, act, exp);
      end
   endtask

   function automatic longint exp_col(input int c, input logic [ADDR_W-1:0] wb,
                                      input logic [ADDR_W-1:0] ib, input int nw, input int ni);
      logic [31:0] s;
      logic [ADDR_W-1:0] aw, ai;
      s = '0;
      if (c < ni) begin
         ai = ib + ADDR_W'(c);
         for (int r = 0; r < nw; r++) begin
            aw = wb + ADDR_W'(r);
            s  = s + 32'(mem[aw]) * 32'(mem[ai]);
         end
      end
      return longint'(s);
   endfunction

   typedef struct {
      logic [ADDR_W-1:0] wb, ib;
      logic [3:0]        nr, nc;
      int                nw, ni, lat;
   } vec_t;
   vec_t vecs [6];

   task automatic run_vec(input int id, input vec_t v, input bit poke);
      int s;
      bit found;
      @(posedge clk); #1;
      w_base = v.wb; i_base = v.ib; num_rows = v.nr; num_cols = v.nc;
      m_wb = v.wb; m_ib = v.ib; m_nw = v.nw; m_ni = v.ni;
      mon_clr = 1'b1; g_clr = 1'b1; start = 1'b1; s = cyc;
      @(posedge clk); #1;
      start = 1'b0; mon_clr = 1'b0; g_clr = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (i == 0) chk("busy_after_start", id, busy, 1);
         if (done_cnt > 0) begin found = 1'b1; break; end
         if (poke) begin
            start = (cyc == s + 4);
            if (cyc == s + 4) begin
               w_base = 10'd900; i_base = 10'd950; num_rows = 4'd9; num_cols = 4'd9;
            end
         end
      end
      chk("done_seen", id, found, 1);
      if (found) begin
         chk("done_latency", id, done_cyc - s, v.lat);
         chk("busy_at_done", id, busy, 0);
      end
      if (poke) begin
         start = 1'b1; w_base = 10'd700; i_base = 10'd710; num_rows = 4'd5; num_cols = 4'd5;
      end
      @(posedge clk); #1;
      start = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      chk("done_count", id, done_cnt, 1);
      chk("weight_beats", id, w_seen, v.nw);
      chk("image_beats", id, i_seen, v.ni);
      chk("reads", id, rd_seen, v.nw + v.ni);
      chk("read_addr_errs", id, rd_err, 0);
      chk("beat_value_errs", id, w_err + i_err, 0);
      chk("beat_gap_errs", id, gap_err, 0);
      chk("bus_overlap", id, ovl_err, 0);
      chk("idle_bus_nonzero", id, idle_err, 0);
      chk("busy_after_done", id, busy, 0);
      if (v.nw + v.ni > 0) chk("first_beat_offset", id, first_beat - s, 3);
      for (int c = 0; c < COLS; c++)
         chk($sformatf("result_col%0d", c), id, longint'(result_out[c*PSUM_W +: PSUM_W]),
             exp_col(c, v.wb, v.ib, v.nw, v.ni));
   endtask

   initial begin
      for (int a = 0; a < 1024; a++) mem[a] = 16'((a * 7 + 3) & 255);
      mem[0] = 16'd3; mem[100] = 16'd30;
      for (int k = 0; k < 16; k++) begin
         mem[200 + k] = 16'(k + 1);
         mem[300 + k] = 16'(10 * k);
      end
      //          wb       ib       nr    nc    nw  ni  lat
      vecs[0] = '{10'd0,   10'd100, 4'd1,  4'd1,  1,  1, 17};
      vecs[1] = '{10'd200, 10'd300, 4'd12, 4'd14, 12, 14, 41};
      vecs[2] = '{10'd200, 10'd300, 4'd15, 4'd0,  12, 0, 27};
      vecs[3] = '{10'd200, 10'd300, 4'd0,  4'd0,  0,  0, 15};
      vecs[4] = '{10'd1022, 10'd400, 4'd4, 4'd3,  4,  3, 22};
      vecs[5] = '{10'd500, 10'd600, 4'd2,  4'd15, 2,  14, 31};

      rst = 1'b1; start = 1'b0; w_base = '0; i_base = '0; num_rows = '0; num_cols = '0;
      m_wb = '0; m_ib = '0; m_nw = 0; m_ni = 0;
      #12;
      chk("reset_outputs_ones", 0, $countones({busy, done, mem_rd_en, mem_rd_addr, weight_val_in,
          tag_row, valid_y, image_val_in, tag_col, valid_x, result_out}), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0; mon_clr = 1'b0; g_clr = 1'b0;

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i], 1'b0);

      // reset abandoned mid-W_ISSUE
      @(posedge clk); #1;
      w_base = 10'd200; i_base = 10'd300; num_rows = 4'd12; num_cols = 4'd14;
      m_wb = 10'd200; m_ib = 10'd300; m_nw = 12; m_ni = 14;
      start = 1'b1; mon_clr = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; mon_clr = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("busy_before_reset", 6, busy, 1);
      chk("rd_en_before_reset", 6, mem_rd_en, 1);
      rst = 1'b1;
      #1;
      chk("reset_async_ones", 6, $countones({busy, done, mem_rd_en, mem_rd_addr, weight_val_in,
          tag_row, valid_y, image_val_in, tag_col, valid_x, result_out}), 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      repeat (40) @(negedge clk);
      #1;
      chk("no_done_after_reset", 6, done_cnt, 0);
      chk("idle_after_reset", 6, busy, 0);
      run_vec(7, vecs[1], 1'b0);

      // start pulses mid-run and in the done cycle must be ignored
      run_vec(8, '{10'd0, 10'd100, 4'd3, 4'd2, 3, 2, 20}, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
